// File: rtl/minilab0_mac_if.sv
// Board-side I/O bundle for the mini-lab MAC: switches and keys in, LEDs and
// six active-low 7-segment digits out.
interface minilab0_mac_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  modport master (
    output KEY, SW,
    input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  KEY, SW,
    output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/minilab0_mac.sv
// Mini-lab MAC: fills two operand FIFOs from constant tables, drains them in
// lock-step into a multiply-accumulate, and shows the 24-bit sum on HEX0..HEX5.
module minilab0_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q;
  logic [PTR_W-1:0]      rdPtr_q;
  logic [PTR_W:0]        count_q;
  logic                  doPush;
  logic                  doPop;

  // Pushes while full and pops while empty are silently dropped here.
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_q <= count_q + 1'b1;
      else if (doPop && !doPush) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end
endmodule

module minilab0_mac #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic CLOCK_50,
  input  logic RST,
  minilab0_mac_if.slave board
);
  localparam int CNT_W = $clog2(DEPTH);
  localparam int PAD_W = ACC_WIDTH - 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] A_VALUE  = DATA_WIDTH'(10);

  typedef enum logic [1:0] {
    FILL = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        fillCnt_q, fillCnt_d;
  logic                    pairValid_q, pairValid_d;
  logic [DATA_WIDTH-1:0]   opA_q, opA_d;
  logic [DATA_WIDTH-1:0]   opB_q, opB_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0] product;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] romB;
  logic [DATA_WIDTH-1:0] fifoAData;
  logic [DATA_WIDTH-1:0] fifoBData;
  logic                  fifoAFull;
  logic                  fifoAEmpty;
  logic                  fifoBFull;
  logic                  fifoBEmpty;
  logic                  showDigits;
  logic                  unusedInputs;

  function automatic logic [6:0] hexSeg(input logic [3:0] nibble);
    case (nibble)
      4'h0: hexSeg = 7'b1000000;
      4'h1: hexSeg = 7'b1111001;
      4'h2: hexSeg = 7'b0100100;
      4'h3: hexSeg = 7'b0110000;
      4'h4: hexSeg = 7'b0011001;
      4'h5: hexSeg = 7'b0010010;
      4'h6: hexSeg = 7'b0000010;
      4'h7: hexSeg = 7'b1111000;
      4'h8: hexSeg = 7'b0000000;
      4'h9: hexSeg = 7'b0010000;
      4'hA: hexSeg = 7'b0001000;
      4'hB: hexSeg = 7'b0000011;
      4'hC: hexSeg = 7'b1000110;
      4'hD: hexSeg = 7'b0100001;
      4'hE: hexSeg = 7'b0000110;
      default: hexSeg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    case (fillCnt_q)
      3'd0:    romB = DATA_WIDTH'(70);
      3'd1:    romB = DATA_WIDTH'(75);
      3'd2:    romB = DATA_WIDTH'(80);
      3'd3:    romB = DATA_WIDTH'(85);
      3'd4:    romB = DATA_WIDTH'(90);
      3'd5:    romB = DATA_WIDTH'(95);
      3'd6:    romB = DATA_WIDTH'(100);
      default: romB = DATA_WIDTH'(105);
    endcase
  end

  minilab0_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) fifoA (
    .clk(CLOCK_50), .rst(RST), .push_i(push), .pop_i(pop), .data_i(A_VALUE),
    .data_o(fifoAData), .full_o(fifoAFull), .empty_o(fifoAEmpty)
  );

  minilab0_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) fifoB (
    .clk(CLOCK_50), .rst(RST), .push_i(push), .pop_i(pop), .data_i(romB),
    .data_o(fifoBData), .full_o(fifoBFull), .empty_o(fifoBEmpty)
  );

  assign product = {{DATA_WIDTH{1'b0}}, opA_q} * {{DATA_WIDTH{1'b0}}, opB_q};

  // Popped pairs spend one cycle in opA/opB before reaching the accumulator,
  // so DONE waits for both FIFOs empty and that stage drained.
  always_comb begin
    state_d     = state_q;
    fillCnt_d   = fillCnt_q;
    pairValid_d = 1'b0;
    opA_d       = opA_q;
    opB_d       = opB_q;
    acc_d       = acc_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (pairValid_q) acc_d = acc_q + {{PAD_W{1'b0}}, product};
    case (state_q)
      FILL: begin
        push = 1'b1;
        if (!fifoAFull && !fifoBFull) begin
          fillCnt_d = fillCnt_q + 1'b1;
          if (fillCnt_q == LAST_IDX) state_d = EXEC;
        end
      end
      EXEC: begin
        pop = !fifoAEmpty && !fifoBEmpty;
        if (pop) begin
          pairValid_d = 1'b1;
          opA_d       = fifoAData;
          opB_d       = fifoBData;
        end
        if (fifoAEmpty && fifoBEmpty && !pairValid_q) state_d = DONE;
      end
      DONE: ;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q     <= FILL;
      fillCnt_q   <= '0;
      pairValid_q <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      fillCnt_q   <= fillCnt_d;
      pairValid_q <= pairValid_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      acc_q       <= acc_d;
    end
  end

  // Digits are blanked while reset is held, even with the display enabled.
  assign showDigits = board.SW[0] && !RST;
  assign board.LEDR = {8'b0, state_q};
  assign board.HEX0 = showDigits ? hexSeg(acc_q[3:0])   : 7'b1111111;
  assign board.HEX1 = showDigits ? hexSeg(acc_q[7:4])   : 7'b1111111;
  assign board.HEX2 = showDigits ? hexSeg(acc_q[11:8])  : 7'b1111111;
  assign board.HEX3 = showDigits ? hexSeg(acc_q[15:12]) : 7'b1111111;
  assign board.HEX4 = showDigits ? hexSeg(acc_q[19:16]) : 7'b1111111;
  assign board.HEX5 = showDigits ? hexSeg(acc_q[23:20]) : 7'b1111111;

  assign unusedInputs = ^{board.KEY, board.SW[9:1]};
endmodule

// File: tb/tb_minilab0_mac.sv
// Directed bench for minilab0_mac: sequencing, FIFO flags, display of the
// 0x001B58 dot product, display enable and mid-run reset.
module tb_minilab0_mac;
  logic clk;
  logic rst;
  int   compareCount;
  int   failCount;

  minilab0_mac_if board();

  minilab0_mac dut (
    .CLOCK_50(clk),
    .RST(rst),
    .board(board)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic [9:0] swVal);
    @(negedge clk);
    rst = rstVal;
    board.SW = swVal;
  endtask

  // 0x001B58 on the display: digits 0,0,1,b,5,8 from HEX5 down to HEX0.
  task automatic checkResult(input string tag);
    checkOutput({tag, "_hex0"}, board.HEX0, 7'b0000000);
    checkOutput({tag, "_hex1"}, board.HEX1, 7'b0010010);
    checkOutput({tag, "_hex2"}, board.HEX2, 7'b0000011);
    checkOutput({tag, "_hex3"}, board.HEX3, 7'b1111001);
    checkOutput({tag, "_hex4"}, board.HEX4, 7'b1000000);
    checkOutput({tag, "_hex5"}, board.HEX5, 7'b1000000);
  endtask

  task automatic checkBlank(input string tag);
    checkOutput(tag, {board.HEX5, board.HEX4, board.HEX3, board.HEX2, board.HEX1, board.HEX0},
                {6{7'b1111111}});
  endtask

  // Called on the negedge at which reset has just been released.
  task automatic runToDone(input string tag);
    int       execCyc = 0;
    int       doneCyc = 0;
    logic [1:0] prevSt = 2'b00;
    logic [1:0] st;
    bit       orderOk = 1'b1;
    bit       upperOk = 1'b1;
    for (int c = 1; c <= 40 && doneCyc == 0; c++) begin
      @(negedge clk);
      st = board.LEDR[1:0];
      if (st < prevSt || st == 2'b11) orderOk = 1'b0;
      prevSt = st;
      if (board.LEDR[9:2] != 8'd0) upperOk = 1'b0;
      if (st == 2'b01 && execCyc == 0) execCyc = c;
      if (st == 2'b10) doneCyc = c;
      if (c == 1) checkOutput({tag, "_zeroDuringFill"}, board.HEX0, 7'b1000000);
      if (c == 7) checkOutput({tag, "_notFullAt7"}, {dut.fifoAFull, dut.fifoBFull}, 2'b00);
      if (c == 8)
        checkOutput({tag, "_fullAt8"},
                    {dut.fifoAFull, dut.fifoBFull, dut.fifoAEmpty, dut.fifoBEmpty}, 4'b1100);
      if (c == 10)
        checkOutput({tag, "_firstMac2BC"}, {board.HEX2, board.HEX1, board.HEX0},
                    {7'b0100100, 7'b0000011, 7'b1000110});
      if (c == 16)
        checkOutput({tag, "_emptyAt16"},
                    {dut.fifoAFull, dut.fifoBFull, dut.fifoAEmpty, dut.fifoBEmpty}, 4'b0011);
      if (c == 17)
        checkOutput({tag, "_emptyAt17"},
                    {dut.fifoAFull, dut.fifoBFull, dut.fifoAEmpty, dut.fifoBEmpty}, 4'b0011);
    end
    checkOutput({tag, "_stateOrder"}, orderOk, 1'b1);
    checkOutput({tag, "_ledrUpperZero"}, upperOk, 1'b1);
    checkOutput({tag, "_sawExec"}, (execCyc > 0 && execCyc < doneCyc), 1'b1);
    checkOutput({tag, "_doneWithin20"}, (doneCyc > 0 && doneCyc <= 20), 1'b1);
  endtask

  initial begin
    bit holdOk;
    compareCount = 0;
    failCount    = 0;
    rst          = 1'b1;
    board.KEY    = 4'b0000;
    board.SW     = 10'b0000000001;

    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("resetLedr", board.LEDR, 10'd0);
    checkBlank("resetHexBlank");

    $display("[TB] first run");
    applyStimulus(1'b0, 10'b0000000001);
    runToDone("run1");
    repeat (2) @(negedge clk);
    checkResult("run1Result");
    checkOutput("run1Ledr", board.LEDR, 10'b0000000010);

    $display("[TB] display enable toggle");
    applyStimulus(1'b0, 10'b0000000000);
    #1;
    checkBlank("swOffBlank");
    applyStimulus(1'b0, 10'b0000000001);
    #1;
    checkResult("swOnAgain");

    holdOk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (board.LEDR !== 10'b0000000010) holdOk = 1'b0;
    end
    checkOutput("doneHeld100", holdOk, 1'b1);
    checkResult("frozenAcc");

    $display("[TB] reset during EXEC");
    applyStimulus(1'b1, 10'b0000000001);
    applyStimulus(1'b0, 10'b0000000001);
    repeat (11) @(negedge clk);
    checkOutput("midExecLedr", board.LEDR, 10'b0000000001);
    rst = 1'b1;
    #1;
    checkOutput("midResetLedr", board.LEDR, 10'd0);
    checkBlank("midResetHexBlank");
    checkOutput("midResetFifoEmpty", {dut.fifoAEmpty, dut.fifoBEmpty}, 2'b11);
    @(negedge clk);
    applyStimulus(1'b0, 10'b0000000001);
    runToDone("run2");
    repeat (2) @(negedge clk);
    checkResult("run2Result");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule

// File: doc/minilab0_mac.md
Name: minilab0_mac

Overview:
- Board-level top for the DE1-SoC mini-lab.
- After reset, an internal sequencer loads two 8-entry FIFOs from constant operand tables.
- It then drains both FIFOs in lock-step through a multiply-accumulate (MAC) unit, forming a dot product.
- The 24-bit result appears on six active-low 7-segment displays; sequencer state appears on LEDR.

Parameters:
- DEPTH, 8, entries per FIFO and operands per vector; the tables below are defined for 8.
- DATA_WIDTH, 8, unsigned operand width.
- ACC_WIDTH, 24, accumulator and result width; equals 6 hex digits.

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- KEY  in  4  push buttons; unused, reserved.
- SW  in  10  SW[0] = display enable; SW[9:1] unused.
- LEDR  out  10  LEDR[1:0] = state code; LEDR[9:2] = 0.
- HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 = least-significant nibble.

Behaviour:
- Reset (async, RST=1):
  - state=FILL; counters, FIFO pointers and accumulator cleared.
  - LEDR=0.
  - HEX all 7'b1111111 (blank).
- Operand tables (ROM, unsigned):
  - A[i] = 10 for i=0..7.
  - B[i] = 70,75,80,85,90,95,100,105.
  - Expected sum = 10*700 = 7000 = 24'h001B58.
- FIFOs:
  - Two synchronous FIFOs, DEPTH x DATA_WIDTH, first-word order preserved.
  - Each has full/empty flags.
  - Push when full and pop when empty are ignored.
- State machine, codes on LEDR[1:0]:
  - FILL (2'b00): each cycle push A[cnt] into FIFO A and B[cnt] into FIFO B. After 8 pushes (both full), go to EXEC.
  - EXEC (2'b01): each cycle with both FIFOs non-empty, pop both.
  - MAC datapath: popped pair registered one cycle. Then acc <= acc + A*B, with a 16-bit product zero-extended to ACC_WIDTH.
  - When the 8th product has been accumulated (FIFOs empty, pipeline drained), go to DONE.
  - DONE (2'b10): accumulator frozen; LEDR[1]=1. State held until reset; no auto-restart.
  - 2'b11 unused; if ever reached, go to FILL.
- Timing: LEDR[1] rises no later than 20 cycles after RST deasserts.
- Arithmetic: accumulator wraps modulo 2^ACC_WIDTH; no saturation.
- Display:
  - SW[0]=1: HEXn shows nibble n of the accumulator (HEX0=acc[3:0] … HEX5=acc[23:20]). Digits 0-F use standard active-low encoding, e.g. 0=1000000, 1=1111001, 5=0010010, 8=0000000, b=0000011.
  - SW[0]=0: all HEX = 1111111.
  - Display is combinational from acc and SW[0], so intermediate values are visible during EXEC.
- Reset mid-operation: immediate return to FILL with FIFOs emptied and acc=0. Full sequence reruns after release.

Test Plan:
- RST=1 two cycles, SW=1 → LEDR=0, all HEX=1111111; after release LEDR[1:0] goes 00→01→10.
- Wait for posedge LEDR[1], then 2 clocks → HEX0=0000000 (8), HEX1=0010010 (5), HEX2=0000011 (b), HEX3=1111001 (1), HEX4=HEX5=1000000 (0), i.e. 0x001B58.
- LEDR[1] rises within 20 cycles of reset release; LEDR[9:2]=0 throughout.
- In DONE toggle SW[0] 1→0→1 → HEX blank, then 0x001B58 again; state stays 2'b10 over 100 cycles.
- Assert RST during EXEC → HEX blank/zero result and LEDR=0 at once; after release, final result is again 0x001B58.
- Check FIFO flags in FILL → full after the 8th push, empty after the 8th pop; no extra push or pop occurs.
